// File: rtl/cache_pkg.sv
// Shared types and address-field width helpers for the direct-mapped write-through cache.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WRITE
    } cache_state_t;

    function automatic int offset_bits(input int word_size);
        return $clog2(word_size / 8);
    endfunction

    function automatic int wordsel_bits(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int index_bits(input int line_count);
        return $clog2(line_count);
    endfunction

    function automatic int tag_bits(input int bit_count, input int word_size,
                                    input int line_words, input int line_count);
        return bit_count - offset_bits(word_size) - wordsel_bits(line_words)
               - index_bits(line_count);
    endfunction

endpackage

// File: rtl/cache_data_array.sv
// Line data storage: one combinational read port, one synchronous byte-enabled write port.
module cache_data_array
    import cache_pkg::*;
#(
    parameter int WORD_SIZE  = 32,
    parameter int LINE_WORDS = 4,
    parameter int LINE_COUNT = 16
) (
    input  logic                            clk,
    input  logic [index_bits(LINE_COUNT)-1:0]   i_rd_index,
    input  logic [wordsel_bits(LINE_WORDS)-1:0] i_rd_wsel,
    output logic [WORD_SIZE-1:0]            o_rd_data,
    input  logic                            i_wr_en,
    input  logic [index_bits(LINE_COUNT)-1:0]   i_wr_index,
    input  logic [wordsel_bits(LINE_WORDS)-1:0] i_wr_wsel,
    input  logic [WORD_SIZE/8-1:0]          i_wr_be,
    input  logic [WORD_SIZE-1:0]            i_wr_data
);
    localparam int BYTES = WORD_SIZE / 8;
    localparam int DEPTH = LINE_COUNT * LINE_WORDS;

    logic [WORD_SIZE-1:0] r_mem [DEPTH];

    assign o_rd_data = r_mem[{i_rd_index, i_rd_wsel}];

    // NOTE: the array has no reset; valid bits in the top decide whether its contents are used.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (i_wr_be[b]) begin
                    r_mem[{i_wr_index, i_wr_wsel}][b*8 +: 8] <= i_wr_data[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dm_write_through_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with line refill over a req/ready bus.
module dm_write_through_cache
    import cache_pkg::*;
#(
    parameter int BIT_COUNT  = 32,
    parameter int WORD_SIZE  = 32,
    parameter int LINE_WORDS = 4,
    parameter int LINE_COUNT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   MemEn,
    input  logic                   MemWrite,
    input  logic [WORD_SIZE/8-1:0] ByteEn,
    input  logic [BIT_COUNT-1:0]   MemAdr,
    input  logic [WORD_SIZE-1:0]   MemWriteData,
    output logic [WORD_SIZE-1:0]   MemReadData,
    output logic                   Stall,
    output logic                   BusReq,
    output logic                   BusWrite,
    output logic [BIT_COUNT-1:0]   BusAdr,
    output logic [WORD_SIZE/8-1:0] BusByteEn,
    output logic [WORD_SIZE-1:0]   BusWriteData,
    input  logic                   BusReady,
    input  logic [WORD_SIZE-1:0]   BusReadData
);
    localparam int OFF_BITS  = offset_bits(WORD_SIZE);
    localparam int WS_BITS   = wordsel_bits(LINE_WORDS);
    localparam int IX_BITS   = index_bits(LINE_COUNT);
    localparam int TAG_BITS  = tag_bits(BIT_COUNT, WORD_SIZE, LINE_WORDS, LINE_COUNT);
    localparam int BYTES     = WORD_SIZE / 8;
    localparam int IX_LSB    = OFF_BITS + WS_BITS;
    localparam int TAG_LSB   = IX_LSB + IX_BITS;
    localparam int WADR_BITS = BIT_COUNT - OFF_BITS;
    localparam logic [WS_BITS-1:0] LAST_BEAT = WS_BITS'(LINE_WORDS - 1);

    cache_state_t r_state, w_next_state;

    logic [LINE_COUNT-1:0]       r_valid;
    logic [TAG_BITS-1:0]         r_tag [LINE_COUNT];
    logic [WS_BITS-1:0]          r_beat;
    logic [BIT_COUNT-IX_LSB-1:0] r_line;      // tag+index of the line being refilled
    logic [WADR_BITS-1:0]        r_st_adr;    // word address of the pending store
    logic [WORD_SIZE-1:0]        r_st_data;
    logic [BYTES-1:0]            r_st_be;

    logic [IX_BITS-1:0]   w_core_index, w_ref_index, w_st_index, w_wr_index;
    logic [TAG_BITS-1:0]  w_core_tag, w_ref_tag, w_st_tag;
    logic [WS_BITS-1:0]   w_core_wsel, w_st_wsel, w_wr_wsel;
    logic                 w_core_hit, w_st_hit, w_last_beat, w_wr_en;
    logic [BYTES-1:0]     w_wr_be;
    logic [WORD_SIZE-1:0] w_wr_data, w_rd_data;

    assign w_core_index = MemAdr[TAG_LSB-1:IX_LSB];
    assign w_core_tag   = MemAdr[BIT_COUNT-1:TAG_LSB];
    assign w_core_wsel  = MemAdr[IX_LSB-1:OFF_BITS];
    assign w_core_hit   = r_valid[w_core_index] && (r_tag[w_core_index] == w_core_tag);

    assign w_ref_index  = r_line[IX_BITS-1:0];
    assign w_ref_tag    = r_line[BIT_COUNT-IX_LSB-1:IX_BITS];
    assign w_st_wsel    = r_st_adr[WS_BITS-1:0];
    assign w_st_index   = r_st_adr[WS_BITS+IX_BITS-1:WS_BITS];
    assign w_st_tag     = r_st_adr[WADR_BITS-1:WS_BITS+IX_BITS];
    assign w_st_hit     = r_valid[w_st_index] && (r_tag[w_st_index] == w_st_tag);
    assign w_last_beat  = (r_beat == LAST_BEAT);

    generate
        if (OFF_BITS > 0) begin : g_byte_offset
            logic w_unused_offset;
            assign w_unused_offset = ^MemAdr[OFF_BITS-1:0];
        end
    endgenerate

    // Refill beats write whole words; store hits merge only the enabled lanes.
    assign w_wr_en    = BusReady && ((r_state == REFILL) || (r_state == WRITE && w_st_hit));
    assign w_wr_index = (r_state == REFILL) ? w_ref_index : w_st_index;
    assign w_wr_wsel  = (r_state == REFILL) ? r_beat : w_st_wsel;
    assign w_wr_be    = (r_state == REFILL) ? '1 : r_st_be;
    assign w_wr_data  = (r_state == REFILL) ? BusReadData : r_st_data;

    cache_data_array #(
        .WORD_SIZE  (WORD_SIZE),
        .LINE_WORDS (LINE_WORDS),
        .LINE_COUNT (LINE_COUNT)
    ) u_data (
        .clk        (clk),
        .i_rd_index (w_core_index),
        .i_rd_wsel  (w_core_wsel),
        .o_rd_data  (w_rd_data),
        .i_wr_en    (w_wr_en),
        .i_wr_index (w_wr_index),
        .i_wr_wsel  (w_wr_wsel),
        .i_wr_be    (w_wr_be),
        .i_wr_data  (w_wr_data)
    );

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (MemEn) begin
                    if (MemWrite)         w_next_state = WRITE;
                    else if (!w_core_hit) w_next_state = REFILL;
                end
            end
            REFILL:  if (BusReady && w_last_beat) w_next_state = IDLE;
            WRITE:   if (BusReady) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        Stall        = 1'b0;
        BusReq       = 1'b0;
        BusWrite     = 1'b0;
        BusAdr       = '0;
        BusByteEn    = '0;
        BusWriteData = '0;
        MemReadData  = '0;
        if (reset) begin
            unique case (r_state)
                IDLE: begin
                    Stall = MemEn && (MemWrite || !w_core_hit);
                    if (MemEn && !MemWrite && w_core_hit) MemReadData = w_rd_data;
                end
                REFILL: begin
                    BusReq = 1'b1;
                    Stall  = 1'b1;
                    BusAdr = BIT_COUNT'({r_line, r_beat}) << OFF_BITS;
                end
                WRITE: begin
                    BusReq       = 1'b1;
                    BusWrite     = 1'b1;
                    BusAdr       = BIT_COUNT'(r_st_adr) << OFF_BITS;
                    BusByteEn    = r_st_be;
                    BusWriteData = r_st_data;
                    Stall        = !BusReady;
                end
                default: ;
            endcase
        end
    end

    // A line is invalidated when its refill starts and only revalidated on the final beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid   <= '0;
            r_beat    <= '0;
            r_line    <= '0;
            r_st_adr  <= '0;
            r_st_data <= '0;
            r_st_be   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (MemEn && MemWrite) begin
                        r_st_adr  <= MemAdr[BIT_COUNT-1:OFF_BITS];
                        r_st_data <= MemWriteData;
                        r_st_be   <= ByteEn;
                    end else if (MemEn && !w_core_hit) begin
                        r_line                <= MemAdr[BIT_COUNT-1:IX_LSB];
                        r_beat                <= '0;
                        r_valid[w_core_index] <= 1'b0;
                    end
                end
                REFILL: begin
                    if (BusReady) begin
                        r_beat <= r_beat + WS_BITS'(1);
                        if (w_last_beat) r_valid[w_ref_index] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == REFILL && BusReady && w_last_beat) r_tag[w_ref_index] <= w_ref_tag;
    end

endmodule

// File: tb/tb_dm_write_through_cache.sv
// Self-checking bench: vector table of core accesses plus a bus model with an expected-beat scoreboard.
module tb_dm_write_through_cache;

    logic        clk;
    logic        reset;
    logic        MemEn, MemWrite;
    logic [3:0]  ByteEn;
    logic [31:0] MemAdr, MemWriteData, MemReadData;
    logic        Stall, BusReq, BusWrite, BusReady;
    logic [31:0] BusAdr, BusWriteData, BusReadData;
    logic [3:0]  BusByteEn;

    dm_write_through_cache #(
        .BIT_COUNT(32), .WORD_SIZE(32), .LINE_WORDS(4), .LINE_COUNT(16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .MemEn        (MemEn),
        .MemWrite     (MemWrite),
        .ByteEn       (ByteEn),
        .MemAdr       (MemAdr),
        .MemWriteData (MemWriteData),
        .MemReadData  (MemReadData),
        .Stall        (Stall),
        .BusReq       (BusReq),
        .BusWrite     (BusWrite),
        .BusAdr       (BusAdr),
        .BusByteEn    (BusByteEn),
        .BusWriteData (BusWriteData),
        .BusReady     (BusReady),
        .BusReadData  (BusReadData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Backing memory: unwritten words read as a fixed function of their address.
    logic [31:0] bmem [int unsigned];

    function automatic logic [31:0] bm_read(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return 32'hD000_0000 ^ a;
    endfunction

    typedef struct {
        logic        wr;
        logic [31:0] adr;
        logic [31:0] data;
        logic [3:0]  be;
    } beat_t;

    beat_t       exp_bus [$];
    logic [31:0] exp_rd  [$];
    int          bus_lat = 1;
    int          r_wait;
    int          n_beats = 0;

    assign BusReady    = BusReq && (r_wait >= bus_lat - 1);
    assign BusReadData = bm_read(BusAdr);

    always @(posedge clk) begin
        if (BusReq && BusReady) begin
            n_beats++;
            if (exp_bus.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL bus_extra: unexpected beat wr=%0b adr=0x%08h", BusWrite, BusAdr);
            end else begin
                beat_t e;
                e = exp_bus.pop_front();
                check("bus_write", 32'(BusWrite), 32'(e.wr));
                check("bus_adr", BusAdr, e.adr);
                if (e.wr) begin
                    check("bus_wdata", BusWriteData, e.data);
                    check("bus_be", 32'(BusByteEn), 32'(e.be));
                end
            end
            if (BusWrite) begin
                logic [31:0] w;
                w = bm_read(BusAdr);
                for (int b = 0; b < 4; b++)
                    if (BusByteEn[b]) w[b*8 +: 8] = BusWriteData[b*8 +: 8];
                bmem[BusAdr] = w;
            end
            r_wait <= 0;
        end else if (BusReq) begin
            r_wait <= r_wait + 1;
        end else begin
            r_wait <= 0;
        end
    end

    // One core access: push expectations, hold the request until Stall drops, compare.
    task automatic access(input string name, input logic wr, input logic [3:0] be,
                          input logic [31:0] adr, input logic [31:0] wdata, input int lat,
                          input logic refill, input logic [31:0] exp_rdata, input int exp_stall);
        int stall_cycles;
        bit done;
        stall_cycles = 0;
        done = 0;
        bus_lat = lat;
        if (refill)
            for (int w = 0; w < 4; w++)
                exp_bus.push_back('{1'b0, (adr & ~32'hF) + 32'(4 * w), 32'h0, 4'h0});
        if (wr) exp_bus.push_back('{1'b1, adr & ~32'h3, wdata, be});
        else    exp_rd.push_back(exp_rdata);
        MemEn = 1'b1; MemWrite = wr; ByteEn = be; MemAdr = adr; MemWriteData = wdata;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (Stall) stall_cycles++;
            else begin
                done = 1;
                if (!wr) check({name, "_rdata"}, MemReadData, exp_rd.pop_front());
                if (exp_stall == 0) check({name, "_busreq"}, 32'(BusReq), 32'h0);
            end
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: Stall still high after 200 cycles", name);
        end
        check({name, "_stall"}, 32'(stall_cycles), 32'(exp_stall));
        @(posedge clk);
        #1;
        MemEn = 1'b0; MemWrite = 1'b0;
        check({name, "_pending_beats"}, 32'(exp_bus.size()), 32'h0);
    endtask

    typedef struct {
        string       name;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] adr;
        logic [31:0] wdata;
        int          lat;
        logic        refill;
        logic [31:0] exp_rdata;
        int          exp_stall;
    } vec_t;

    vec_t vecs [$];

    initial begin
        int base;
        bit hit_two;

        vecs.push_back('{"cold_ld40",   1'b0, 4'h0, 32'h040, 32'h0,         1, 1'b1, 32'hD000_0040, 5});
        vecs.push_back('{"hit_ld44",    1'b0, 4'h0, 32'h044, 32'h0,         1, 1'b0, 32'h1122_3344, 0});
        vecs.push_back('{"st44_merge",  1'b1, 4'h3, 32'h044, 32'hAABB_CCDD, 3, 1'b0, 32'h0,        3});
        vecs.push_back('{"reld44",      1'b0, 4'h0, 32'h044, 32'h0,         1, 1'b0, 32'h1122_CCDD, 0});
        vecs.push_back('{"st200_miss",  1'b1, 4'hF, 32'h200, 32'hCAFE_F00D, 1, 1'b0, 32'h0,        1});
        vecs.push_back('{"ld200_miss",  1'b0, 4'h0, 32'h200, 32'h0,         1, 1'b1, 32'hCAFE_F00D, 5});
        vecs.push_back('{"conf_ld440",  1'b0, 4'h0, 32'h440, 32'h0,         1, 1'b1, 32'hD000_0440, 5});
        vecs.push_back('{"conf_ld40",   1'b0, 4'h0, 32'h040, 32'h0,         1, 1'b1, 32'hD000_0040, 5});
        vecs.push_back('{"conf_ld44",   1'b0, 4'h0, 32'h044, 32'h0,         1, 1'b0, 32'h1122_CCDD, 0});
        vecs.push_back('{"hit_ld4c",    1'b0, 4'h0, 32'h04C, 32'h0,         1, 1'b0, 32'hD000_004C, 0});
        vecs.push_back('{"st48_hi",     1'b1, 4'hC, 32'h048, 32'h5566_7788, 2, 1'b0, 32'h0,        2});
        vecs.push_back('{"reld48",      1'b0, 4'h0, 32'h048, 32'h0,         1, 1'b0, 32'h5566_0048, 0});
        vecs.push_back('{"st304_miss",  1'b1, 4'hF, 32'h304, 32'h1234_5678, 1, 1'b0, 32'h0,        1});
        vecs.push_back('{"hit_ld204",   1'b0, 4'h0, 32'h204, 32'h0,         1, 1'b0, 32'hD000_0204, 0});
        vecs.push_back('{"slow_ld80",   1'b0, 4'h0, 32'h080, 32'h0,         2, 1'b1, 32'hD000_0080, 9});

        bmem[32'h44] = 32'h1122_3344;
        reset = 1'b0;
        MemEn = 1'b1; MemWrite = 1'b0; ByteEn = 4'h0; MemAdr = 32'h40; MemWriteData = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_stall", 32'(Stall), 32'h0);
        check("rst_busreq", 32'(BusReq), 32'h0);
        check("rst_rdata", MemReadData, 32'h0);
        @(posedge clk);
        #1;
        MemEn = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i])
            access(vecs[i].name, vecs[i].wr, vecs[i].be, vecs[i].adr, vecs[i].wdata,
                   vecs[i].lat, vecs[i].refill, vecs[i].exp_rdata, vecs[i].exp_stall);

        // Reset after two of four refill beats: the transaction is abandoned.
        bus_lat = 1;
        for (int w = 0; w < 4; w++)
            exp_bus.push_back('{1'b0, 32'hC0 + 32'(4 * w), 32'h0, 4'h0});
        base = n_beats;
        hit_two = 0;
        MemEn = 1'b1; MemWrite = 1'b0; MemAdr = 32'hC0;
        for (int c = 0; c < 50 && !hit_two; c++) begin
            @(posedge clk);
            #1;
            if (n_beats >= base + 2) hit_two = 1;
        end
        check("midrst_two_beats", 32'(n_beats - base), 32'h2);
        reset = 1'b0;
        #1;
        check("midrst_busreq", 32'(BusReq), 32'h0);
        check("midrst_stall", 32'(Stall), 32'h0);
        check("midrst_rdata", MemReadData, 32'h0);
        check("midrst_left_beats", 32'(exp_bus.size()), 32'h2);
        exp_bus.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        MemEn = 1'b0;
        @(posedge clk);
        #1;
        access("post_rst_ldc0", 1'b0, 4'h0, 32'h0C0, 32'h0, 1, 1'b1, 32'hD000_00C0, 5);
        access("post_rst_ld44", 1'b0, 4'h0, 32'h044, 32'h0, 1, 1'b1, 32'h1122_CCDD, 5);
        access("post_rst_ldc8", 1'b0, 4'h0, 32'h0C8, 32'h0, 1, 1'b0, 32'hD000_00C8, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/dm_write_through_cache.md
Name: dm_write_through_cache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the compute core's data-memory port and a multi-cycle backing-memory bus.
- Replaces the zero-latency data storage of the uncached core. It presents the same MemEn/MemWrite/ByteEn/MemAdr/MemWriteData/MemReadData interface to the core, plus a Stall output.
- Refills whole lines through a req/ready word handshake.

Parameters:
- BIT_COUNT, 32, address width in bits.
- WORD_SIZE, 32, data word width in bits; power of two, at least 8.
- LINE_WORDS, 4, words per line; power of two, at least 2.
- LINE_COUNT, 16, number of lines; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemEn  in  1  core access request.
- MemWrite  in  1  1 = store, 0 = load.
- ByteEn  in  WORD_SIZE/8  store byte lanes.
- MemAdr  in  BIT_COUNT  byte address; low log2(WORD_SIZE/8) bits ignored.
- MemWriteData  in  WORD_SIZE  store data.
- MemReadData  out  WORD_SIZE  load data; valid when MemEn & !MemWrite & !Stall.
- Stall  out  1  core must hold its request and not advance.
- BusReq  out  1  backing-memory request.
- BusWrite  out  1  1 = bus write.
- BusAdr  out  BIT_COUNT  word-aligned bus address.
- BusByteEn  out  WORD_SIZE/8  bus write lanes.
- BusWriteData  out  WORD_SIZE  bus write data.
- BusReady  in  1  beat accepted (write) or read data valid (read).
- BusReadData  in  WORD_SIZE  read beat data.

Behaviour:
- Address fields, from the LSB up:
  - byte offset: log2(WORD_SIZE/8) bits
  - word select: log2(LINE_WORDS) bits
  - index: log2(LINE_COUNT) bits
  - tag: the remaining bits
- Per-line state: valid bit, tag, LINE_WORDS data words.
- While reset is low:
  - all valid bits clear; FSM to IDLE; refill beat counter 0.
  - BusReq = 0, BusWrite = 0, Stall = 0, MemReadData = 0.
- A reset taken mid-refill or mid-write abandons the transaction. The partly filled line stays invalid.
- FSM states: IDLE, REFILL, WRITE.
- IDLE:
  - Load hit: MemReadData is driven combinationally from the array the same cycle; Stall = 0; zero-wait.
  - Load miss: Stall = 1; go to REFILL; latch the line base address, beat counter = 0.
  - Store (hit or miss): Stall = 1; go to WRITE; latch address, data and ByteEn.
  - MemEn = 0: no action; Stall = 0.
- REFILL:
  - BusReq = 1, BusWrite = 0, BusAdr = line base + beat counter × (WORD_SIZE/8); Stall = 1.
  - On BusReady: BusReadData is written to word[beat counter] of the indexed line, and the counter increments.
  - Beats are issued in order, word 0 to LINE_WORDS−1; no critical-word-first.
  - On the final beat's BusReady: set the tag, set valid, return to IDLE.
  - The next cycle, the held load hits. Miss penalty is LINE_WORDS accepted beats + 1 cycle.
  - The valid bit stays 0 until the final beat.
  - The refill completes even if the core drops MemEn.
- WRITE:
  - BusReq = 1, BusWrite = 1; BusAdr/BusByteEn/BusWriteData from the latched store; Stall = !BusReady.
  - On BusReady: if the latched tag hits a valid line, merge the enabled bytes into the cached word (disabled lanes unchanged). Then return to IDLE.
  - A store miss does not allocate.
  - The core advances on the BusReady edge; there is no duplicate bus write.
- Bus rules:
  - BusReq, BusAdr and BusWrite stay stable until BusReady.
  - BusReady may arrive in the same cycle BusReq rises.
  - BusReady is ignored when BusReq = 0.
  - BusReq is 0 in IDLE.
- Index wrap: a line refilled at an index overwrites any previous tag (direct-mapped replacement).
- The cache keeps no dirty state; the backing memory is always current.

Decomposition:
- Package cache_pkg:
  - cache_state_t enum {IDLE, REFILL, WRITE}
  - localparam functions for OFFSET_BITS, WORDSEL_BITS, INDEX_BITS, TAG_BITS from the parameters.
- Sub-module cache_data_array: LINE_COUNT × LINE_WORDS × WORD_SIZE storage.
  - One combinational read port.
  - One synchronous write port with per-byte enables.
  - Used for both refill writes (all lanes) and store merges.
- Tags and valid bits stay in the top-level with the FSM.

Test Plan:
- Cold load, MemAdr = 0x40, LINE_WORDS = 4, BusReady every cycle → 4 beats at 0x40/0x44/0x48/0x4C; Stall high 5 cycles; data = beat at 0x40.
- Load 0x44 after that refill → Stall = 0 and BusReq = 0 in the same cycle; data = word 1 of the refilled line.
- Store 0x44, ByteEn = 0011, data 0xAABBCCDD, over cached 0x11223344, BusReady after 3 cycles → exactly one bus write; Stall high 3 cycles; reload 0x44 hits with 0x1122CCDD.
- Store to an uncached 0x200, then load 0x200 → write passes through without allocating; the load misses and refills.
- Conflict: load 0x40 then 0x440 (same index with LINE_COUNT = 16 and 16-byte lines), then 0x40 again → three refills.
- Reset driven low after 2 of 4 refill beats, then released; load the same address → BusReq = 0 immediately on reset; full 4-beat refill afterwards; no hit on stale data.
